// File: rtl/r2sdf_stage_fx_if.sv
// Stream, twiddle-ROM and output signals of one R2SDF butterfly stage.
interface r2sdf_stage_fx_if #(
    parameter int unsigned N  = 3,
    parameter int unsigned DW = 16,
    parameter int unsigned TW = 16
);
    logic                 in_valid;
    logic signed [DW-1:0] in_re;
    logic signed [DW-1:0] in_im;
    logic [N-2:0]         tw_addr;
    logic signed [TW-1:0] tw_re;
    logic signed [TW-1:0] tw_im;
    logic                 out_valid;
    logic signed [DW-1:0] out_re;
    logic signed [DW-1:0] out_im;

    // Source side: feeds samples, serves the twiddle ROM, consumes outputs.
    modport master (
        output in_valid, in_re, in_im, tw_re, tw_im,
        input  tw_addr, out_valid, out_re, out_im
    );

    // Stage side.
    modport slave (
        input  in_valid, in_re, in_im, tw_re, tw_im,
        output tw_addr, out_valid, out_re, out_im
    );
endinterface

// File: rtl/r2sdf_stage_fx.sv
// Fixed-point radix-2 single-delay-feedback DIF butterfly stage.
// Phase 0 fills the feedback line and emits the rotated previous differences;
// phase 1 emits sums and stores differences. Stalls freeze all state.
module r2sdf_stage_fx #(
    parameter int unsigned N     = 3,
    parameter int unsigned STAGE = 1,
    parameter int unsigned DW    = 16,
    parameter int unsigned TW    = 16,
    parameter int unsigned SCALE = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    r2sdf_stage_fx_if.slave  bus
);
    localparam int unsigned D  = 1 << (N - STAGE);
    localparam int unsigned CW = N - STAGE + 1;
    localparam int unsigned AW = N - 1;
    localparam int unsigned SW = DW + 1;
    localparam int unsigned PW = DW + TW + 1;
    localparam logic signed [PW-1:0] RND = PW'(1) << (TW - 2);

    typedef logic signed [DW-1:0] sample_t;

    logic [CW-1:0]  cnt_q, cnt_d;
    logic           primed_q, primed_d;
    sample_t        dl_re_q [D];
    sample_t        dl_im_q [D];
    logic           out_valid_q, out_valid_d;
    sample_t        out_re_q, out_re_d;
    sample_t        out_im_q, out_im_d;

    logic           phase_c;
    logic [AW-1:0]  tw_addr_c;
    sample_t        head_re, head_im;
    logic signed [SW-1:0] sum_re, sum_im, dif_re, dif_im;
    logic signed [PW-1:0] prod_re, prod_im;
    sample_t        bfly_re, bfly_im;
    sample_t        mul_re, mul_im;
    sample_t        push_re, push_im;

    // Butterfly scaling: floor-halve, or saturate the DW+1-bit result.
    function automatic sample_t scale_sat(input logic signed [SW-1:0] v);
        sample_t r;
        if (SCALE != 0) begin
            r = v[DW:1];
        end else if (v[DW] != v[DW-1]) begin
            r = v[DW] ? {1'b1, {(DW-1){1'b0}}} : {1'b0, {(DW-1){1'b1}}};
        end else begin
            r = v[DW-1:0];
        end
        return r;
    endfunction

    // Round-half-up from Q1.(TW-1) back to DW bits with saturation.
    function automatic sample_t round_sat(input logic signed [PW-1:0] p);
        logic signed [PW-1:0] t;
        sample_t              r;
        t = (p + RND) >>> (TW - 1);
        if ((&t[PW-1:DW-1]) | ~(|t[PW-1:DW-1])) begin
            r = t[DW-1:0];
        end else begin
            r = t[PW-1] ? {1'b1, {(DW-1){1'b0}}} : {1'b0, {(DW-1){1'b1}}};
        end
        return r;
    endfunction

    assign phase_c = cnt_q[CW-1];
    assign head_re = dl_re_q[0];
    assign head_im = dl_im_q[0];

    // Twiddle index k comes from the counter's low bits; the last stage has none.
    generate
        if (STAGE < N) begin : g_addr
            assign tw_addr_c = AW'(cnt_q[N-STAGE-1:0]) << (STAGE - 1);
        end else begin : g_addr_zero
            assign tw_addr_c = '0;
        end
    endgenerate

    assign bus.tw_addr   = tw_addr_c;
    assign bus.out_valid = out_valid_q;
    assign bus.out_re    = out_re_q;
    assign bus.out_im    = out_im_q;

    // Butterfly and twiddle datapath; address 0 bypasses the multiplier.
    always_comb begin
        sum_re  = SW'(head_re) + SW'(bus.in_re);
        sum_im  = SW'(head_im) + SW'(bus.in_im);
        dif_re  = SW'(head_re) - SW'(bus.in_re);
        dif_im  = SW'(head_im) - SW'(bus.in_im);
        bfly_re = scale_sat(sum_re);
        bfly_im = scale_sat(sum_im);
        prod_re = PW'(head_re) * PW'(bus.tw_re) - PW'(head_im) * PW'(bus.tw_im);
        prod_im = PW'(head_re) * PW'(bus.tw_im) + PW'(head_im) * PW'(bus.tw_re);
        mul_re  = head_re;
        mul_im  = head_im;
        if (tw_addr_c != '0) begin
            mul_re = round_sat(prod_re);
            mul_im = round_sat(prod_im);
        end
        push_re = bus.in_re;
        push_im = bus.in_im;
        if (phase_c) begin
            push_re = scale_sat(dif_re);
            push_im = scale_sat(dif_im);
        end
    end

    // Next-state: counter, priming flag and output register contents.
    always_comb begin
        cnt_d       = cnt_q;
        primed_d    = primed_q;
        out_valid_d = 1'b0;
        out_re_d    = out_re_q;
        out_im_d    = out_im_q;
        if (bus.in_valid) begin
            cnt_d = cnt_q + CW'(1);
            if (cnt_d[CW-1]) begin
                primed_d = 1'b1;
            end
            if (primed_q) begin
                out_valid_d = 1'b1;
                out_re_d    = phase_c ? bfly_re : mul_re;
                out_im_d    = phase_c ? bfly_im : mul_im;
            end
        end
    end

    // Control and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q       <= '0;
            primed_q    <= 1'b0;
            out_valid_q <= 1'b0;
            out_re_q    <= '0;
            out_im_q    <= '0;
        end else begin
            cnt_q       <= cnt_d;
            primed_q    <= primed_d;
            out_valid_q <= out_valid_d;
            out_re_q    <= out_re_d;
            out_im_q    <= out_im_d;
        end
    end

    // Feedback delay line: shifts toward the head on each accepted sample.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(D); i++) begin
                dl_re_q[i] <= '0;
                dl_im_q[i] <= '0;
            end
        end else if (bus.in_valid) begin
            for (int i = 0; i < int'(D) - 1; i++) begin
                dl_re_q[i] <= dl_re_q[i+1];
                dl_im_q[i] <= dl_im_q[i+1];
            end
            dl_re_q[D-1] <= push_re;
            dl_im_q[D-1] <= push_im;
        end
    end
endmodule

// File: tb/tb_r2sdf_stage_fx.sv
// Directed bench for r2sdf_stage_fx: reset, ramp, stalls, saturation,
// scaling and a second-stage instance, all with N=3.
module tb_r2sdf_stage_fx;
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int ov, ore, oim, oaddr;
    int idx, nout, c, acc;
    logic v;

    int exp_re [8] = '{6, 8, 10, 12, -4, -3, 0, 3};
    int exp_im [8] = '{0, 0, 0, 0, 0, 3, 4, 3};

    r2sdf_stage_fx_if #(.N(3), .DW(16), .TW(16)) bus_a ();
    r2sdf_stage_fx_if #(.N(3), .DW(16), .TW(16)) bus_b ();
    r2sdf_stage_fx_if #(.N(3), .DW(16), .TW(16)) bus_c ();

    r2sdf_stage_fx #(.N(3), .STAGE(1), .DW(16), .TW(16), .SCALE(0)) u_a (
        .clk(clk), .rst_n(rst_n), .bus(bus_a.slave));
    r2sdf_stage_fx #(.N(3), .STAGE(1), .DW(16), .TW(16), .SCALE(1)) u_b (
        .clk(clk), .rst_n(rst_n), .bus(bus_b.slave));
    r2sdf_stage_fx #(.N(3), .STAGE(2), .DW(16), .TW(16), .SCALE(0)) u_c (
        .clk(clk), .rst_n(rst_n), .bus(bus_c.slave));

    function automatic logic signed [15:0] rom_re(input logic [1:0] a);
        case (a)
            2'd0:    rom_re = 16'sd32767;
            2'd1:    rom_re = 16'sd23170;
            2'd2:    rom_re = 16'sd0;
            default: rom_re = -16'sd23170;
        endcase
    endfunction

    function automatic logic signed [15:0] rom_im(input logic [1:0] a);
        case (a)
            2'd0:    rom_im = 16'sd0;
            2'd1:    rom_im = -16'sd23170;
            2'd2:    rom_im = -16'sd32767;
            default: rom_im = -16'sd23170;
        endcase
    endfunction

    // Twiddle ROMs for the three stages.
    always_comb begin
        bus_a.tw_re = rom_re(bus_a.tw_addr);
        bus_a.tw_im = rom_im(bus_a.tw_addr);
        bus_b.tw_re = rom_re(bus_b.tw_addr);
        bus_b.tw_im = rom_im(bus_b.tw_addr);
        bus_c.tw_re = rom_re(bus_c.tw_addr);
        bus_c.tw_im = rom_im(bus_c.tw_addr);
    end

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // One clock: drive the selected stage, capture tw_addr before the edge
    // and the registered outputs just after it.
    task automatic beat(input int sel, input logic vin, input int re, input int im);
        @(negedge clk);
        bus_a.in_valid = (sel == 0) && vin;
        bus_b.in_valid = (sel == 1) && vin;
        bus_c.in_valid = (sel == 2) && vin;
        bus_a.in_re = 16'(re);  bus_a.in_im = 16'(im);
        bus_b.in_re = 16'(re);  bus_b.in_im = 16'(im);
        bus_c.in_re = 16'(re);  bus_c.in_im = 16'(im);
        #1;
        case (sel)
            0:       oaddr = int'(bus_a.tw_addr);
            1:       oaddr = int'(bus_b.tw_addr);
            default: oaddr = int'(bus_c.tw_addr);
        endcase
        @(posedge clk);
        #1;
        case (sel)
            0: begin
                ov = int'(bus_a.out_valid); ore = int'(bus_a.out_re); oim = int'(bus_a.out_im);
            end
            1: begin
                ov = int'(bus_b.out_valid); ore = int'(bus_b.out_re); oim = int'(bus_b.out_im);
            end
            default: begin
                ov = int'(bus_c.out_valid); ore = int'(bus_c.out_re); oim = int'(bus_c.out_im);
            end
        endcase
    endtask

    task automatic idle_all();
        bus_a.in_valid = 1'b0;
        bus_b.in_valid = 1'b0;
        bus_c.in_valid = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        idle_all();
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0;
        idle_all();
        bus_a.in_re = '0; bus_a.in_im = '0;
        bus_b.in_re = '0; bus_b.in_im = '0;
        bus_c.in_re = '0; bus_c.in_im = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_valid", int'(bus_a.out_valid), 0);
        chk("rst_re", int'(bus_a.out_re), 0);
        chk("rst_im", int'(bus_a.out_im), 0);
        chk("rst_addr", int'(bus_a.tw_addr), 0);
        chk("rst_valid_c", int'(bus_c.out_valid), 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Reset asserted mid-stream, away from any clock edge.
        for (int i = 1; i <= 6; i++) beat(0, 1'b1, i, 0);
        chk("pre_rst_valid", ov, 1);
        chk("pre_rst_re", ore, 8);
        #2;
        rst_n = 1'b0;
        idle_all();
        #1;
        chk("midrst_valid", int'(bus_a.out_valid), 0);
        chk("midrst_re", int'(bus_a.out_re), 0);
        chk("midrst_im", int'(bus_a.out_im), 0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            beat(0, 1'b1, i, 0);
            chk($sformatf("reprime_v%0d", i), ov, (i == 5) ? 1 : 0);
        end
        chk("reprime_re", ore, 6);

        // Ramp frame 1..8 then four zeros.
        do_reset();
        for (int i = 0; i < 12; i++) begin
            beat(0, 1'b1, (i < 8) ? i + 1 : 0, 0);
            if (i < 4) begin
                chk($sformatf("ramp_v%0d", i), ov, 0);
                chk($sformatf("ramp_addr%0d", i), oaddr, i);
            end else begin
                chk($sformatf("ramp_v%0d", i), ov, 1);
                chk($sformatf("ramp_re%0d", i), ore, exp_re[i-4]);
                chk($sformatf("ramp_im%0d", i), oim, exp_im[i-4]);
            end
            if (i >= 8) chk($sformatf("ramp_addr%0d", i), oaddr, i - 8);
        end

        // Same stream with every third beat idle.
        do_reset();
        idx = 0; nout = 0; c = 0;
        while (idx < 12 && c < 100) begin
            v = (c % 3) != 2;
            acc = idx;
            beat(0, v, (idx < 8) ? idx + 1 : 0, 0);
            chk($sformatf("stall_v%0d", c), ov, (v && acc >= 4) ? 1 : 0);
            if (ov == 1 && nout < 8) begin
                chk($sformatf("stall_re%0d", nout), ore, exp_re[nout]);
                chk($sformatf("stall_im%0d", nout), oim, exp_im[nout]);
                nout++;
            end else if (!v && nout > 0) begin
                chk($sformatf("stall_hold%0d", c), ore, exp_re[nout-1]);
            end
            if (v) idx++;
            c++;
        end
        chk("stall_count", nout, 8);
        chk("stall_accepted", idx, 12);

        // Saturation of the sum, exact zero difference.
        do_reset();
        for (int i = 0; i < 9; i++) begin
            beat(0, 1'b1, (i < 8) ? 32767 : 0, (i < 8) ? -32768 : 0);
            if (i == 4) begin
                chk("sat_sum_re", ore, 32767);
                chk("sat_sum_im", oim, -32768);
            end
            if (i == 8) begin
                chk("sat_dif_v", ov, 1);
                chk("sat_dif_re", ore, 0);
                chk("sat_dif_im", oim, 0);
            end
        end

        // Scaled butterfly: 3 paired with 4.
        do_reset();
        for (int i = 0; i < 10; i++) begin
            beat(1, 1'b1, (i == 0) ? 3 : ((i == 4) ? 4 : 0), 0);
            if (i == 4) chk("scale_sum", ore, 3);
            if (i == 8) chk("scale_dif", ore, -1);
            if (i == 9) chk("scale_next", ore, 0);
        end

        // Second stage, D=2, constant (1,1) frame then two flush zeros.
        do_reset();
        for (int i = 0; i < 6; i++) begin
            beat(2, 1'b1, (i < 4) ? 1 : 0, (i < 4) ? 1 : 0);
            if (i < 2 || i >= 4) chk($sformatf("s2_addr%0d", i), oaddr, (i % 2) * 2);
            if (i < 2) begin
                chk($sformatf("s2_v%0d", i), ov, 0);
            end else begin
                chk($sformatf("s2_v%0d", i), ov, 1);
                chk($sformatf("s2_re%0d", i), ore, (i < 4) ? 2 : 0);
                chk($sformatf("s2_im%0d", i), oim, (i < 4) ? 2 : 0);
            end
        end

        @(negedge clk);
        idle_all();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
